// File: rtl/coprosit_regfile_writeback_if.sv
// Result-source bus for the posit register file writeback arbiter.
// One valid/ready/addr/data lane per functional unit.
interface coprosit_regfile_writeback_if #(
    parameter int NR_SRC     = 3,
    parameter int DATA_WIDTH = 32
);
    logic [NR_SRC-1:0]                 src_valid_i;
    logic [NR_SRC-1:0]                 src_ready_o;
    logic [NR_SRC-1:0][4:0]            src_addr_i;
    logic [NR_SRC-1:0][DATA_WIDTH-1:0] src_data_i;

    modport master (
        output src_valid_i,
        output src_addr_i,
        output src_data_i,
        input  src_ready_o
    );

    modport slave (
        input  src_valid_i,
        input  src_addr_i,
        input  src_data_i,
        output src_ready_o
    );
endinterface

// File: rtl/coprosit_regfile_writeback.sv
// Round-robin writeback arbiter for the posit register file write port,
// plus the 32-entry pending-write scoreboard used by issue hazard checks.
module coprosit_regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int NR_SRC     = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    coprosit_regfile_writeback_if.slave src,
    input  logic                      issue_valid_i,
    input  logic [4:0]                issue_addr_i,
    output logic [31:0]               busy_o,
    output logic                      rf_we_o,
    output logic [4:0]                rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      stray_o
);
    localparam int PW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    logic [PW-1:0]         r_ptr;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [31:0]           r_busy;

    logic                  w_found;
    logic [PW-1:0]         w_gnt;
    logic [NR_SRC-1:0]     w_ready;
    logic [PW-1:0]         w_ptr_nxt;
    logic [31:0]           w_busy_nxt;

    function automatic int wrap(input int a);
        return a % NR_SRC;
    endfunction

    // First valid source at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_ready = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            if (!w_found && src.src_valid_i[wrap(int'(r_ptr) + i)]) begin
                w_found = 1'b1;
                w_gnt   = PW'(wrap(int'(r_ptr) + i));
            end
        end
        if (w_found) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_found) begin
            w_ptr_nxt = PW'(wrap(int'(w_gnt) + 1));
        end
    end

    // Clear on the committed write, then set on issue so a new writer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (issue_valid_i) begin
            w_busy_nxt[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_we   <= w_found;
            r_busy <= w_busy_nxt;
            if (w_found) begin
                r_waddr <= src.src_addr_i[w_gnt];
                r_wdata <= src.src_data_i[w_gnt];
            end
        end
    end

    assign src.src_ready_o = w_ready;
    assign busy_o          = r_busy;
    assign rf_we_o         = r_we;
    assign rf_waddr_o      = r_waddr;
    assign rf_wdata_o      = r_wdata;
    assign stray_o         = r_we & ~r_busy[r_waddr];
endmodule

// File: tb/tb_coprosit_regfile_writeback.sv
// Bench for the posit writeback arbiter: vector table for arbitration,
// write scoreboard queue, and directed scoreboard/reset sequences.
module tb_coprosit_regfile_writeback;
    localparam int NS = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iss_v = 1'b0;
    logic [4:0]    iss_a = '0;
    logic [31:0]   busy;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stray;

    coprosit_regfile_writeback_if #(.NR_SRC(NS), .DATA_WIDTH(DW)) bus ();

    coprosit_regfile_writeback #(.DATA_WIDTH(DW), .NR_SRC(NS)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .src           (bus),
        .issue_valid_i (iss_v),
        .issue_addr_i  (iss_a),
        .busy_o        (busy),
        .rf_we_o       (rf_we),
        .rf_waddr_o    (rf_waddr),
        .rf_wdata_o    (rf_wdata),
        .stray_o       (stray)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          we;
        logic [4:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  m_ptr = 0;
    int  g;
    int  k;
    logic [NS-1:0] m_rdy;

    // Reference arbiter and write scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_we", 32'(rf_we), 32'(e.we));
            if (e.we) begin
                chk("sb_waddr", 32'(rf_waddr), 32'(e.a));
                chk("sb_wdata", rf_wdata, e.d);
            end
        end
        g = -1;
        for (int i = 0; i < NS; i++) begin
            k = (m_ptr + i) % NS;
            if (g < 0 && bus.src_valid_i[k]) g = k;
        end
        m_rdy = '0;
        if (g >= 0) m_rdy[g] = 1'b1;
        chk("mon_ready", 32'(bus.src_ready_o), 32'(m_rdy));
        if (rst) begin
            exp_q.push_back('{we: 1'b0, a: 5'd0, d: '0});
            m_ptr = 0;
        end else if (g >= 0) begin
            exp_q.push_back('{we: 1'b1, a: bus.src_addr_i[g],
                              d: bus.src_data_i[g]});
            m_ptr = (g + 1) % NS;
        end else begin
            exp_q.push_back('{we: 1'b0, a: 5'd0, d: '0});
        end
    end

    typedef struct {
        logic [NS-1:0] v;
        logic [NS-1:0] rdy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Pointer starts at 1 when the table is applied.
        tbl[0]  = '{3'b101, 3'b100};
        tbl[1]  = '{3'b101, 3'b001};
        tbl[2]  = '{3'b101, 3'b100};
        tbl[3]  = '{3'b000, 3'b000};
        tbl[4]  = '{3'b010, 3'b010};
        tbl[5]  = '{3'b011, 3'b001};
        tbl[6]  = '{3'b111, 3'b010};
        tbl[7]  = '{3'b111, 3'b100};
        tbl[8]  = '{3'b110, 3'b010};
        tbl[9]  = '{3'b110, 3'b100};
        tbl[10] = '{3'b001, 3'b001};
        tbl[11] = '{3'b100, 3'b100};

        bus.src_valid_i = '1;
        for (int s = 0; s < NS; s++) begin
            bus.src_addr_i[s] = 5'(s + 1);
            bus.src_data_i[s] = 32'hA0 + 32'(s);
        end

        tick();
        tick();
        chk("rst_busy", busy, 32'h0);
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_stray", 32'(stray), 32'h0);
        rst = 1'b0;
        chk("rst_first_ready", 32'(bus.src_ready_o), 32'h1);

        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_we", 32'(rf_we), 32'h1);
            chk("rr_waddr", 32'(rf_waddr), 32'((i % 3) + 1));
            chk("rr_wdata", rf_wdata, 32'hA0 + 32'(i % 3));
            chk("rr_stray", 32'(stray), 32'h1);
        end
        bus.src_valid_i = '0;
        tick();
        chk("idle_we", 32'(rf_we), 32'h0);

        bus.src_valid_i = 3'b001;
        tick();
        for (int i = 0; i < 12; i++) begin
            bus.src_valid_i = tbl[i].v;
            #1;
            chk("tbl_ready", 32'(bus.src_ready_o), 32'(tbl[i].rdy));
            tick();
        end

        bus.src_valid_i = '0;
        bus.src_addr_i[1] = 5'd5;
        bus.src_data_i[1] = 32'h5555_0005;
        iss_v = 1'b1;
        iss_a = 5'd5;
        tick();
        iss_v = 1'b0;
        chk("life_busy_set", 32'(busy[5]), 32'h1);
        tick();
        tick();
        bus.src_valid_i = 3'b010;
        tick();
        bus.src_valid_i = '0;
        chk("life_we", 32'(rf_we), 32'h1);
        chk("life_waddr", 32'(rf_waddr), 32'h5);
        chk("life_busy_hold", 32'(busy[5]), 32'h1);
        chk("life_stray", 32'(stray), 32'h0);
        tick();
        chk("life_busy_clr", 32'(busy[5]), 32'h0);

        iss_v = 1'b1;
        iss_a = 5'd7;
        tick();
        iss_v = 1'b0;
        bus.src_addr_i[0] = 5'd7;
        bus.src_valid_i = 3'b001;
        tick();
        bus.src_valid_i = '0;
        chk("sbc_waddr", 32'(rf_waddr), 32'h7);
        chk("sbc_stray", 32'(stray), 32'h0);
        iss_v = 1'b1;
        iss_a = 5'd7;
        tick();
        iss_v = 1'b0;
        chk("sbc_busy7", 32'(busy[7]), 32'h1);

        bus.src_addr_i[0] = 5'd9;
        bus.src_data_i[0] = 32'h0000_0099;
        bus.src_valid_i = 3'b001;
        tick();
        bus.src_valid_i = '0;
        chk("stray_pulse", 32'(stray), 32'h1);
        tick();
        chk("stray_end", 32'(stray), 32'h0);

        iss_v = 1'b1;
        iss_a = 5'd12;
        bus.src_addr_i[2] = 5'd4;
        bus.src_data_i[2] = 32'h0000_0044;
        bus.src_valid_i = 3'b100;
        tick();
        iss_v = 1'b0;
        bus.src_valid_i = '0;
        chk("mr_we_pre", 32'(rf_we), 32'h1);
        chk("mr_busy12", 32'(busy[12]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_we", 32'(rf_we), 32'h0);
        chk("mr_busy", busy, 32'h0);
        chk("mr_stray", 32'(stray), 32'h0);
        bus.src_valid_i = '1;
        #1;
        chk("mr_ready", 32'(bus.src_ready_o), 32'h1);
        tick();
        chk("mr_waddr", 32'(rf_waddr), 32'h9);
        bus.src_valid_i = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
